// File: rtl/fan_speed.sv
// rtl/fan_speed.sv - fixed-period PWM fan enable with boundary-latched duty
// Optional soft-start duty ramp: define FAN_SPEED_SOFTSTART_EN.
module fan_speed #(
  parameter int WIDTH     = 8,
  parameter int SOFT_STEP = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] speed,
  output logic             pwm_data
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] duty;
  logic [WIDTH-1:0] duty_next;

  // A zero step would freeze the soft-start ramp forever.
  if (SOFT_STEP < 1) begin : g_bad_soft_step
    $error("fan_speed: SOFT_STEP must be at least 1");
  end

`ifdef FAN_SPEED_SOFTSTART_EN
  localparam logic [WIDTH+1:0] STEP = (WIDTH+2)'(SOFT_STEP);

  // Two guard bits keep duty +/- STEP from wrapping before the clamp.
  always_comb begin
    duty_next = duty;
    if (speed > duty) begin
      if ({2'b00, duty} + STEP > {2'b00, speed})
        duty_next = speed;
      else
        duty_next = WIDTH'({2'b00, duty} + STEP);
    end else if (speed < duty) begin
      if ({2'b00, duty} < {2'b00, speed} + STEP)
        duty_next = speed;
      else
        duty_next = WIDTH'({2'b00, duty} - STEP);
    end
  end
`else
  always_comb begin
    duty_next = speed;
  end
`endif

  always_ff @(posedge clk) begin
    if (arst) begin
      cnt <= '0;
`ifdef FAN_SPEED_SOFTSTART_EN
      duty <= '0;
`else
      duty <= speed;
`endif
    end else begin
      cnt <= cnt + WIDTH'(1);
      // Duty only moves at the wrap so a period is never cut short.
      if (cnt == '1)
        duty <= duty_next;
    end
  end

  assign pwm_data = (cnt < duty) && !arst;

endmodule

// File: tb/tb_fan_speed.sv
// tb/tb_fan_speed.sv - scoreboard bench for fan_speed (WIDTH=8, SOFT_STEP=8)
module tb_fan_speed;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] speed;
  logic       pwm_data;

  bit sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fan_speed #(.WIDTH(8), .SOFT_STEP(8)) dut (
    .clk      (clk),
    .arst     (arst),
    .speed    (speed),
    .pwm_data (pwm_data)
  );

  // Inputs change just after the rising edge; output is sampled at the falling edge.
  task automatic cyc(input logic a, input logic [7:0] s);
    @(posedge clk);
    #1;
    arst  = a;
    speed = s;
    @(negedge clk);
  endtask

  task automatic push_period(input int d);
    for (int i = 0; i < 256; i++) sb.push_back(i < d);
  endtask

  task automatic test_reset();
    bit e;
    for (int i = 0; i < 3; i++) sb.push_back(1'b0);
    push_period(64);
    push_period(64);
    for (int c = 0; c < 3 + 512; c++) begin
      cyc(c < 3, 8'h40);
      e = sb.pop_front();
      n_cmp++;
      if (pwm_data !== e) begin
        n_bad++;
        $display("FAIL reset_0x40 cycle %0d: pwm_data=%b expected %b", c, pwm_data, e);
      end
    end
  endtask

  task automatic test_zero_full();
    bit e;
    int         exp_d[5] = '{64, 0, 0, 255, 255};
    logic [7:0] spd[5]   = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF};
    for (int p = 0; p < 5; p++) push_period(exp_d[p]);
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 256; c++) begin
        cyc(1'b0, spd[p]);
        e = sb.pop_front();
        n_cmp++;
        if (pwm_data !== e) begin
          n_bad++;
          $display("FAIL zero_full period %0d cnt %0d: pwm_data=%b expected %b", p, c, pwm_data, e);
        end
      end
    end
  endtask

  task automatic test_mid_change();
    bit e;
    logic [7:0] s;
    push_period(255);
    push_period(64);
    push_period(192);
    push_period(192);
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 256; c++) begin
        s = (p == 0 || (p == 1 && c < 100)) ? 8'h40 : 8'hC0;
        cyc(1'b0, s);
        e = sb.pop_front();
        n_cmp++;
        if (pwm_data !== e) begin
          n_bad++;
          $display("FAIL mid_change period %0d cnt %0d: pwm_data=%b expected %b", p, c, pwm_data, e);
        end
      end
    end
  endtask

  task automatic test_boundary_edge();
    bit e;
    logic [7:0] s;
    push_period(192);
    push_period(128);
    push_period(16);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 256; c++) begin
        if (p == 0) s = (c == 255) ? 8'h80 : 8'h40;
        else        s = 8'h10;
        cyc(1'b0, s);
        e = sb.pop_front();
        n_cmp++;
        if (pwm_data !== e) begin
          n_bad++;
          $display("FAIL boundary_edge period %0d cnt %0d: pwm_data=%b expected %b", p, c, pwm_data, e);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    bit e;
    push_period(16);
    for (int i = 0; i < 30; i++) sb.push_back(1'b1);
    sb.push_back(1'b0);
    push_period(64);
    push_period(64);
    for (int c = 0; c < 256 + 31 + 512; c++) begin
      cyc(c == 256 + 30, 8'h40);
      e = sb.pop_front();
      n_cmp++;
      if (pwm_data !== e) begin
        n_bad++;
        $display("FAIL mid_reset cycle %0d: pwm_data=%b expected %b", c, pwm_data, e);
      end
    end
  endtask

  task automatic test_softstart();
    bit e;
    logic [7:0] s;
    for (int i = 0; i < 3; i++) sb.push_back(1'b0);
    for (int k = 0; k <= 8; k++) push_period(8 * k);
    for (int k = 8; k >= 0; k--) push_period(8 * k);
    push_period(0);
    for (int c = 0; c < 3 + 19 * 256; c++) begin
      s = (c < 3 + 9 * 256) ? 8'h40 : 8'h00;
      cyc(c < 3, s);
      e = sb.pop_front();
      n_cmp++;
      if (pwm_data !== e) begin
        n_bad++;
        $display("FAIL softstart cycle %0d: pwm_data=%b expected %b", c, pwm_data, e);
      end
    end
  endtask

  initial begin
    arst  = 1'b1;
    speed = 8'h40;
`ifdef FAN_SPEED_SOFTSTART_EN
    test_softstart();
`else
    test_reset();
    test_zero_full();
    test_mid_change();
    test_boundary_edge();
    test_mid_reset();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
